// File: rtl/pulse_burst_gen.sv
// Burst pulse generator: emits N one-cycle pulses separated by a programmable low gap,
// then a one-cycle done strobe. All outputs come straight from flops.
module pulse_burst_gen #(
  parameter int CNT_W = 4,
  parameter int PER_W = 26
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [PER_W-1:0] period,
  input  logic             abort,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    GAP    = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PER_W-1:0] PER_ONE = {{(PER_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [PER_W-1:0] gap_q, gap_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // A zero gap would collapse two pulses into one wide pulse, so it is stretched to one cycle.
  function automatic logic [PER_W-1:0] clamp_period(input logic [PER_W-1:0] p);
    return (p == '0) ? PER_ONE : p;
  endfunction

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    per_d   = per_q;
    gap_d   = gap_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (count != '0) begin
            state_d = PULSE;
            rem_d   = count - CNT_ONE;
            per_d   = clamp_period(period);
          end else begin
            state_d = FINISH;
            rem_d   = '0;
          end
        end
      end
      PULSE: begin
        if (rem_q != '0) begin
          state_d = GAP;
          gap_d   = per_q;
        end else begin
          state_d = FINISH;
        end
      end
      GAP: begin
        gap_d = gap_q - PER_ONE;
        if (gap_q == PER_ONE) begin
          state_d = PULSE;
          rem_d   = rem_q - CNT_ONE;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything; a pulse already on the line completes its cycle.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      rem_d   = '0;
      gap_d   = '0;
    end

    pulse_d = (state_d == PULSE);
    busy_d  = (state_d == PULSE) || (state_d == GAP);
    done_d  = (state_d == FINISH);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      rem_q   <= '0;
      per_q   <= '0;
      gap_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      per_q   <= per_d;
      gap_q   <= gap_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Bench for pulse_burst_gen: directed scenarios plus random traffic, checked every cycle
// against a schedule model that computes outputs from the burst's start edge arithmetically.
module tb_pulse_burst_gen;
  localparam int CNT_W = 4;
  localparam int PER_W = 26;

  logic             clk = 1'b0;
  logic             resetn;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [PER_W-1:0] period;
  logic             abort;
  logic             pulse_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] remaining;
  logic [6:0]       obs;

  int errors = 0;
  int checks = 0;

  // Reference schedule: burst accepted at edge m_e with m_n pulses spaced m_sp cycles apart.
  bit         m_act = 1'b0;
  int         m_c   = 0;
  int         m_e   = 0;
  int         m_n   = 0;
  int         m_sp  = 2;
  logic [6:0] exp_vec;

  always #5 clk = ~clk;

  pulse_burst_gen #(.CNT_W(CNT_W), .PER_W(PER_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .count     (count),
    .period    (period),
    .abort     (abort),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  assign obs = {pulse_out, busy, done, remaining};

  function automatic int m_last();
    return (m_n == 0) ? 0 : (m_n - 1) * m_sp + 1;
  endfunction

  function automatic logic m_idle();
    return !m_act || ((m_c - m_e) > m_last());
  endfunction

  function automatic logic [6:0] model_out();
    int u;
    int len;
    int r;
    logic p, b, d;
    logic [CNT_W-1:0] rv;
    p = 1'b0; b = 1'b0; d = 1'b0; r = 0;
    if (m_act) begin
      u = m_c - m_e;
      if (m_n == 0) begin
        d = (u == 0);
      end else begin
        len = (m_n - 1) * m_sp;
        b = (u >= 0) && (u <= len);
        p = b && ((u % m_sp) == 0);
        r = b ? (m_n - 1 - u / m_sp) : 0;
        d = (u == len + 1);
      end
    end
    rv = r[CNT_W-1:0];
    return {p, b, d, rv};
  endfunction

  task automatic step(input logic s, input logic [CNT_W-1:0] cnt,
                      input logic [PER_W-1:0] per, input logic ab);
    logic idle_now;
    @(negedge clk);
    start = s; count = cnt; period = per; abort = ab;
    @(posedge clk);
    idle_now = m_idle();
    if (!idle_now && ab) begin
      m_act = 1'b0;
    end else if (idle_now && s && !ab) begin
      m_act = 1'b1;
      m_e   = m_c + 1;
      m_n   = int'(cnt);
      m_sp  = (per == '0) ? 2 : int'(per) + 1;
    end
    m_c++;
    #1;
    exp_vec = model_out();
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; abort = 1'b0; count = '0; period = '0;
    repeat (3) @(posedge clk);
    #1;
    if (obs !== 7'd0) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", obs, 7'd0);
    end
    checks++;
    @(negedge clk);
    resetn = 1'b1;
    m_act = 1'b0;
  endtask

  task automatic test_basic();
    int np = 0, nd = 0, nb = 0;
    int pos[3];
    for (int i = 0; i < 11; i++) begin
      step(i == 0, 4'd3, 26'd2, 1'b0);
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL basic step=%0d got=%b exp=%b", i, obs, exp_vec);
      end
      checks++;
      if (pulse_out && np < 3) pos[np] = i;
      if (pulse_out) np++;
      if (done) nd++;
      if (busy) nb++;
    end
    if (np !== 3 || pos[0] !== 0 || pos[1] !== 3 || pos[2] !== 6 || nd !== 1 || nb !== 7) begin
      errors++;
      $display("FAIL basic_shape got pulses=%0d at %0d,%0d,%0d done=%0d busy=%0d exp 3 at 0,3,6 done=1 busy=7",
               np, pos[0], pos[1], pos[2], nd, nb);
    end
    checks++;
  endtask

  task automatic test_zero();
    int np = 0, nd = 0, nb = 0;
    int p0 = -1, p1 = -1;
    for (int i = 0; i < 4; i++) begin
      step(i == 0, 4'd0, 26'd5, 1'b0);
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL zero_count step=%0d got=%b exp=%b", i, obs, exp_vec);
      end
      checks++;
      if (pulse_out) np++;
      if (done) nd++;
      if (busy) nb++;
    end
    if (np !== 0 || nd !== 1 || nb !== 0) begin
      errors++;
      $display("FAIL zero_count_shape got pulses=%0d done=%0d busy=%0d exp 0/1/0", np, nd, nb);
    end
    checks++;
    np = 0;
    for (int i = 0; i < 6; i++) begin
      step(i == 0, 4'd2, 26'd0, 1'b0);
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL zero_period step=%0d got=%b exp=%b", i, obs, exp_vec);
      end
      checks++;
      if (pulse_out) begin
        if (np == 0) p0 = i; else p1 = i;
        np++;
      end
    end
    if (np !== 2 || p0 !== 0 || p1 !== 2) begin
      errors++;
      $display("FAIL zero_period_spacing got pulses=%0d at %0d,%0d exp 2 at 0,2", np, p0, p1);
    end
    checks++;
  endtask

  task automatic test_start_while_busy();
    int np = 0, nd = 0;
    for (int i = 0; i < 11; i++) begin
      if (i == 0) step(1'b1, 4'd4, 26'd1, 1'b0);
      else        step(i == 2, 4'd9, 26'd7, 1'b0);
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL busy_start step=%0d got=%b exp=%b", i, obs, exp_vec);
      end
      checks++;
      if (pulse_out) np++;
      if (done) nd++;
    end
    if (np !== 4 || nd !== 1) begin
      errors++;
      $display("FAIL busy_start_count got pulses=%0d done=%0d exp 4/1", np, nd);
    end
    checks++;
  endtask

  task automatic test_abort();
    int late_p = 0, nd = 0, nb = 0;
    for (int i = 0; i < 36; i++) begin
      step(i == 0, 4'd6, 26'd4, i == 6);
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL abort step=%0d got=%b exp=%b", i, obs, exp_vec);
      end
      checks++;
      if (i >= 6 && pulse_out) late_p++;
      if (done) nd++;
    end
    if (late_p !== 0 || nd !== 0) begin
      errors++;
      $display("FAIL abort_after got late_pulses=%0d done=%0d exp 0/0", late_p, nd);
    end
    checks++;
    for (int i = 0; i < 4; i++) begin
      step(i == 0, 4'd5, 26'd2, i == 0);
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL abort_start_idle step=%0d got=%b exp=%b", i, obs, exp_vec);
      end
      checks++;
      if (busy || pulse_out || done) nb++;
    end
    if (nb !== 0) begin
      errors++;
      $display("FAIL abort_start_idle_quiet got active_cycles=%0d exp 0", nb);
    end
    checks++;
  endtask

  task automatic test_reset_mid_burst();
    int np = 0, nd = 0;
    for (int i = 0; i < 7; i++) begin
      step(i == 0, 4'd5, 26'd3, 1'b0);
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL reset_mid step=%0d got=%b exp=%b", i, obs, exp_vec);
      end
      checks++;
    end
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    if (obs !== 7'd0) begin
      errors++;
      $display("FAIL reset_async got=%b exp=%b", obs, 7'd0);
    end
    checks++;
    m_act = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (obs !== 7'd0) begin
      errors++;
      $display("FAIL reset_hold got=%b exp=%b", obs, 7'd0);
    end
    checks++;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(i == 0, 4'd5, 26'd3, 1'b0);
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL reset_fresh step=%0d got=%b exp=%b", i, obs, exp_vec);
      end
      checks++;
      if (pulse_out) np++;
      if (done) nd++;
    end
    if (np !== 5 || nd !== 1) begin
      errors++;
      $display("FAIL reset_fresh_count got pulses=%0d done=%0d exp 5/1", np, nd);
    end
    checks++;
  endtask

  task automatic test_loopback();
    int lb_cnt = 3, wraps = 0, wrap_at = 0, np = 0, rem_exp = 14;
    for (int i = 0; i < 16; i++) begin
      step(i == 0, 4'd3, 26'd5, 1'b0);
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL loopback step=%0d got=%b exp=%b", i, obs, exp_vec);
      end
      checks++;
      if (pulse_out) begin
        np++;
        if (lb_cnt == 1) begin
          wraps++;
          wrap_at = np;
          lb_cnt = 3;
        end else begin
          lb_cnt--;
        end
      end
    end
    if (wraps !== 1 || wrap_at !== 3) begin
      errors++;
      $display("FAIL loopback_wrap got wraps=%0d at_pulse=%0d exp 1 at 3", wraps, wrap_at);
    end
    checks++;
    np = 0;
    for (int i = 0; i < 33; i++) begin
      step(i == 0, 4'd15, 26'd0, 1'b0);
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL max_burst step=%0d got=%b exp=%b", i, obs, exp_vec);
      end
      checks++;
      if (pulse_out) begin
        np++;
        if (int'(remaining) !== rem_exp) begin
          errors++;
          $display("FAIL max_remaining pulse=%0d got=%0d exp=%0d", np, remaining, rem_exp);
        end
        checks++;
        rem_exp--;
      end
    end
    if (np !== 15) begin
      errors++;
      $display("FAIL max_count got pulses=%0d exp 15", np);
    end
    checks++;
  endtask

  task automatic test_random();
    logic s, ab;
    logic [CNT_W-1:0] c;
    logic [PER_W-1:0] p;
    for (int i = 0; i < 600; i++) begin
      s  = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 39) == 0);
      c  = CNT_W'($urandom_range(0, 15));
      p  = PER_W'($urandom_range(0, 3));
      step(s, c, p, ab);
      if (obs !== exp_vec) begin
        errors++;
        $display("FAIL random step=%0d got=%b exp=%b", i, obs, exp_vec);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_start_while_busy();
    test_abort();
    test_reset_mid_burst();
    test_loopback();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
